// File: rtl/serial_pkg.sv
// Shared UART framing definitions: FSM state encoding, parity modes and the parity helper.
package serial_pkg;

  localparam int unsigned DATA_BITS_W = 8;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } serial_state_e;

  // Even parity makes the total count of ones (data + parity) even.
  function automatic logic parity_bit(input logic [DATA_BITS_W-1:0] data,
                                      input int unsigned             mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Counts baud ticks within one bit period and flags the tick that ends the bit.
module serial_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_tick_cnt;

  // A clear on the same edge as a tick wins, so that tick is never counted.
  assign o_bit_end = i_tick && !i_clear && (r_tick_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (i_clear) begin
      r_tick_cnt <= '0;
    end else if (i_tick) begin
      r_tick_cnt <= (r_tick_cnt == LAST_CNT) ? '0 : r_tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned NUM_STOP_BITS = 1,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned PARITY        = PARITY_NONE
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick,
  input  logic                   i_en,
  input  logic                   i_start,
  input  logic [DATA_BITS_W-1:0] i_data_in,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS_W - 1);
  localparam logic [2:0] LAST_STOP  = 3'(NUM_STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

  serial_state_e          r_state, w_state_d;
  logic [DATA_BITS_W-1:0] r_shift, w_shift_d;
  logic [2:0]             r_bit_idx, w_bit_idx_d;
  logic                   r_parity, w_parity_d;
  logic                   r_tx, w_tx_d;
  logic                   r_busy, w_busy_d;
  logic                   r_done, w_done_d;
  logic                   w_active;
  logic                   w_clear;
  logic                   w_bit_end;

  assign w_active = r_state inside {START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT};
  // Timer runs only inside a frame; acceptance therefore restarts it from zero.
  assign w_clear  = !i_en || !w_active;

  serial_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_tick    (i_tick),
    .i_clear   (w_clear),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_bit_idx_d = r_bit_idx;
    w_parity_d  = r_parity;
    w_tx_d      = r_tx;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;

    if (!i_en) begin
      w_state_d   = IDLE;
      w_bit_idx_d = '0;
      w_tx_d      = 1'b1;
      w_busy_d    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_tx_d   = 1'b1;
          w_busy_d = 1'b0;
          if (i_start) begin
            w_shift_d   = i_data_in;
            w_bit_idx_d = '0;
            w_parity_d  = parity_bit(i_data_in, PARITY);
            w_tx_d      = 1'b0;
            w_busy_d    = 1'b1;
            w_state_d   = START_BIT;
          end
        end
        START_BIT: begin
          if (w_bit_end) begin
            w_state_d = DATA_BITS;
            w_tx_d    = r_shift[0];
          end
        end
        DATA_BITS: begin
          if (w_bit_end) begin
            w_shift_d = r_shift >> 1;
            if (r_bit_idx == LAST_DATA) begin
              w_bit_idx_d = '0;
              if (HAS_PARITY) begin
                w_state_d = PARITY_BIT;
                w_tx_d    = r_parity;
              end else begin
                w_state_d = STOP_BIT;
                w_tx_d    = 1'b1;
              end
            end else begin
              w_bit_idx_d = r_bit_idx + 3'd1;
              w_tx_d      = r_shift[1];
            end
          end
        end
        PARITY_BIT: begin
          if (w_bit_end) begin
            w_state_d   = STOP_BIT;
            w_bit_idx_d = '0;
            w_tx_d      = 1'b1;
          end
        end
        STOP_BIT: begin
          w_tx_d = 1'b1;
          if (w_bit_end) begin
            if (r_bit_idx == LAST_STOP) begin
              w_state_d   = IDLE;
              w_bit_idx_d = '0;
              w_busy_d    = 1'b0;
              w_done_d    = 1'b1;
            end else begin
              w_bit_idx_d = r_bit_idx + 3'd1;
            end
          end
        end
        default: begin
          w_state_d   = IDLE;
          w_bit_idx_d = '0;
          w_tx_d      = 1'b1;
          w_busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_bit_idx <= w_bit_idx_d;
      r_parity  <= w_parity_d;
      r_tx      <= w_tx_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
